// File: rtl/rect_writer.sv
// Fills an axis-aligned rectangle, clipped to the screen, into an image RAM write port.
// Pixels stream one per cycle in raster order; a one-cycle done pulse marks completion.
module rect_writer #(
  parameter logic [7:0] XMAX = 8'd160,
  parameter logic [6:0] YMAX = 7'd120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] width,
  input  logic [6:0] height,
  input  logic [2:0] color,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_write,
  output logic [6:0] y_write,
  output logic [2:0] color_in,
  output logic       wren
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] xc_q, xc_d;
  logic [6:0] yc_q, yc_d;
  logic [7:0] xs_q, xs_d;
  logic [8:0] xend_q, xend_d;
  logic [7:0] yend_q, yend_d;
  logic [2:0] color_q, color_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wren_q, wren_d;
  logic [7:0] x_write_q, x_write_d;
  logic [6:0] y_write_q, y_write_d;
  logic [2:0] color_in_q, color_in_d;

  logic [8:0] x_sum_s, x_lim_s;
  logic [7:0] y_sum_s, y_lim_s;
  logic       empty_s, x_last_s, y_last_s;

  // Clipped bounds use one extra bit so x0+width never wraps before the min().
  assign x_sum_s  = {1'b0, x0} + {1'b0, width};
  assign y_sum_s  = {1'b0, y0} + {1'b0, height};
  assign x_lim_s  = (x_sum_s > {1'b0, XMAX}) ? {1'b0, XMAX} : x_sum_s;
  assign y_lim_s  = (y_sum_s > {1'b0, YMAX}) ? {1'b0, YMAX} : y_sum_s;
  assign empty_s  = (width == 8'd0) || (height == 7'd0) || (x0 >= XMAX) || (y0 >= YMAX);
  assign x_last_s = ({1'b0, xc_q} == (xend_q - 9'd1));
  assign y_last_s = ({1'b0, yc_q} == (yend_q - 8'd1));

  // Next-state and next-output logic; outputs describe the pixel shown in the following cycle.
  always_comb begin
    state_d    = state_q;
    xc_d       = xc_q;
    yc_d       = yc_q;
    xs_d       = xs_q;
    xend_d     = xend_q;
    yend_d     = yend_q;
    color_d    = color_q;
    busy_d     = busy_q;
    done_d     = done_q;
    wren_d     = wren_q;
    x_write_d  = x_write_q;
    y_write_d  = y_write_q;
    color_in_d = color_in_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          xs_d    = x0;
          color_d = color;
          xend_d  = x_lim_s;
          yend_d  = y_lim_s;
          xc_d    = x0;
          yc_d    = y0;
          busy_d  = 1'b1;
          if (empty_s) begin
            state_d = DONE;
            done_d  = 1'b1;
            wren_d  = 1'b0;
          end else begin
            state_d    = WRITE;
            done_d     = 1'b0;
            wren_d     = 1'b1;
            x_write_d  = x0;
            y_write_d  = y0;
            color_in_d = color;
          end
        end else begin
          busy_d = 1'b0;
          done_d = 1'b0;
          wren_d = 1'b0;
        end
      end
      WRITE: begin
        if (x_last_s && y_last_s) begin
          state_d = DONE;
          wren_d  = 1'b0;
          done_d  = 1'b1;
        end else if (x_last_s) begin
          xc_d      = xs_q;
          yc_d      = yc_q + 7'd1;
          wren_d    = 1'b1;
          x_write_d = xs_q;
          y_write_d = yc_q + 7'd1;
        end else begin
          xc_d      = xc_q + 8'd1;
          wren_d    = 1'b1;
          x_write_d = xc_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wren_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wren_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      xc_q       <= 8'd0;
      yc_q       <= 7'd0;
      xs_q       <= 8'd0;
      xend_q     <= 9'd0;
      yend_q     <= 8'd0;
      color_q    <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wren_q     <= 1'b0;
      x_write_q  <= 8'd0;
      y_write_q  <= 7'd0;
      color_in_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      xc_q       <= xc_d;
      yc_q       <= yc_d;
      xs_q       <= xs_d;
      xend_q     <= xend_d;
      yend_q     <= yend_d;
      color_q    <= color_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wren_q     <= wren_d;
      x_write_q  <= x_write_d;
      y_write_q  <= y_write_d;
      color_in_q <= color_in_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wren     = wren_q;
  assign x_write  = x_write_q;
  assign y_write  = y_write_q;
  assign color_in = color_in_q;

endmodule

// File: tb/tb_rect_writer.sv
// Self-checking bench for rect_writer: directed cases plus random commands checked
// against a clipped-rectangle pixel list built with plain loops.
module tb_rect_writer;

  localparam int XS = 160;
  localparam int YS = 120;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] width;
  logic [6:0] height;
  logic [2:0] color;
  logic       busy;
  logic       done;
  logic [7:0] x_write;
  logic [6:0] y_write;
  logic [2:0] color_in;
  logic       wren;

  int checks;
  int errors;

  rect_writer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .width    (width),
    .height   (height),
    .color    (color),
    .busy     (busy),
    .done     (done),
    .x_write  (x_write),
    .y_write  (y_write),
    .color_in (color_in),
    .wren     (wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    x0     = 8'($urandom);
    y0     = 7'($urandom);
    width  = 8'($urandom);
    height = 7'($urandom);
    color  = 3'($urandom);
  endtask

  // Issue one command and check every cycle until the controller is idle again.
  task automatic run_cmd(input int ax0, input int ay0, input int aw, input int ah,
                         input int ac, input bit inj_busy, input bit inj_done);
    int xq[$];
    int yq[$];
    int xe;
    int ye;
    xe = (ax0 + aw > XS) ? XS : ax0 + aw;
    ye = (ay0 + ah > YS) ? YS : ay0 + ah;
    for (int yy = ay0; yy < ye; yy++) begin
      for (int xx = ax0; xx < xe; xx++) begin
        xq.push_back(xx);
        yq.push_back(yy);
      end
    end
    x0     = 8'(ax0);
    y0     = 7'(ay0);
    width  = 8'(aw);
    height = 7'(ah);
    color  = 3'(ac);
    start  = 1'b1;
    cyc();
    start = 1'b0;
    scramble();
    for (int i = 0; i < xq.size(); i++) begin
      chk("wr_ctl", {29'd0, busy, done, wren}, 32'd5);
      chk("wr_x", {24'd0, x_write}, 32'(xq[i]));
      chk("wr_y", {25'd0, y_write}, 32'(yq[i]));
      chk("wr_col", {29'd0, color_in}, 32'(ac));
      if (inj_busy && i == 1) begin
        start = 1'b1;
        color = 3'(ac) ^ 3'b111;
      end else begin
        start = 1'b0;
      end
      cyc();
    end
    start = 1'b0;
    chk("done_ctl", {29'd0, busy, done, wren}, 32'd6);
    if (inj_done) begin
      x0     = 8'd1;
      y0     = 7'd1;
      width  = 8'd1;
      height = 7'd1;
      start  = 1'b1;
    end
    cyc();
    start = 1'b0;
    chk("idle_ctl", {29'd0, busy, done, wren}, 32'd0);
    cyc();
    chk("idle2_ctl", {29'd0, busy, done, wren}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    x0     = 8'd3;
    y0     = 7'd3;
    width  = 8'd2;
    height = 7'd2;
    color  = 3'd7;
    start  = 1'b1;
    cyc();
    cyc();
    chk("rst_ctl", {29'd0, busy, done, wren}, 32'd0);
    chk("rst_x", {24'd0, x_write}, 32'd0);
    chk("rst_y", {25'd0, y_write}, 32'd0);
    chk("rst_col", {29'd0, color_in}, 32'd0);
    reset = 1'b1;
    start = 1'b0;
    cyc();
    chk("rst_start_discard", {29'd0, busy, done, wren}, 32'd0);

    run_cmd(10, 5, 3, 2, 2, 1'b0, 1'b0);
    run_cmd(158, 118, 5, 5, 4, 1'b0, 1'b0);
    run_cmd(10, 5, 0, 4, 1, 1'b0, 1'b0);
    run_cmd(200, 5, 4, 4, 1, 1'b0, 1'b0);
    run_cmd(5, 119, 3, 0, 6, 1'b0, 1'b0);
    run_cmd(30, 40, 3, 3, 5, 1'b1, 1'b0);
    run_cmd(70, 80, 2, 2, 3, 1'b0, 1'b1);
    run_cmd(159, 119, 1, 1, 7, 1'b0, 1'b0);

    // Reset on the third write cycle of a 4x4 fill aborts without a done pulse.
    x0     = 8'd20;
    y0     = 7'd30;
    width  = 8'd4;
    height = 7'd4;
    color  = 3'd5;
    start  = 1'b1;
    cyc();
    start = 1'b0;
    chk("ab_first", {29'd0, busy, done, wren}, 32'd5);
    cyc();
    cyc();
    chk("ab_third_x", {24'd0, x_write}, 32'd22);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("ab_ctl", {29'd0, busy, done, wren}, 32'd0);
    chk("ab_x", {24'd0, x_write}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("ab_quiet", {29'd0, busy, done, wren}, 32'd0);
    end
    run_cmd(50, 60, 1, 1, 3, 1'b0, 1'b0);

    run_cmd(0, 0, 160, 120, 6, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int rx;
      int ry;
      rx = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 200) : $urandom_range(0, 159);
      ry = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
      run_cmd(rx, ry, $urandom_range(0, 12), $urandom_range(0, 6), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_writer.md
RECT_WRITER -- requirements
Module: rect_writer

Interface
REQ-001 Parameter XMAX, default 8'd160, horizontal screen size in pixels; valid x is 0..XMAX-1.
REQ-002 Parameter YMAX, default 7'd120, vertical screen size in pixels; valid y is 0..YMAX-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 start  input  1  request a rectangle fill; accepted only in IDLE.
REQ-006 x0  input  8  left column of rectangle.
REQ-007 y0  input  7  top row of rectangle.
REQ-008 width  input  8  rectangle width in pixels; 0 is legal.
REQ-009 height  input  7  rectangle height in pixels; 0 is legal.
REQ-010 color  input  3  fill color.
REQ-011 busy  output  1  high while a command is in progress (states WRITE and DONE).
REQ-012 done  output  1  one-cycle pulse on command completion.
REQ-013 x_write  output  8  write column to image_ram write port.
REQ-014 y_write  output  7  write row to image_ram write port.
REQ-015 color_in  output  3  write data to image_ram write port.
REQ-016 wren  output  1  write enable to image_ram write port; one pixel per cycle.

Function
REQ-017 FSM states IDLE, WRITE, DONE; all outputs registered.
REQ-018 IDLE with start=1: latch x0, y0, color; compute clipped bounds; next state WRITE, or DONE if clipped area is empty.
REQ-019 Bounds are computed in 9-bit (x) and 8-bit (y) arithmetic: xend = min(x0+width, XMAX), yend = min(y0+height, YMAX); no wrap-around.
REQ-020 Clipped area is empty when width=0, height=0, x0>=XMAX or y0>=YMAX.
REQ-021 Counters xc/yc start at (x0,y0); the first wren cycle is the cycle immediately after the start edge.
REQ-022 In WRITE: wren=1, x_write=xc, y_write=yc, color_in=latched color, every cycle.
REQ-023 Scan order is raster: xc increments each cycle; at xc=xend-1 xc reloads x0 and yc increments.
REQ-024 The last pixel (xend-1, yend-1) moves the FSM to DONE; the total count of wren cycles is exactly (xend-x0)*(yend-y0).
REQ-025 DONE lasts exactly one cycle with done=1 and wren=0, then returns to IDLE.
REQ-026 start while busy=1 is ignored; no queueing.
REQ-027 Input changes after acceptance have no effect on the command in progress.
REQ-028 start in the same cycle as the DONE state is ignored; a new command is accepted in IDLE on the next cycle at the earliest.
REQ-029 No pixel outside the clipped rectangle is ever written; wren=0 in IDLE and DONE.

Reset
REQ-030 When reset=0 at a clock edge: state IDLE, busy=0, done=0, wren=0, x_write=0, y_write=0, color_in=0, counters cleared.
REQ-031 Reset asserted mid-WRITE aborts the command: wren=0 from the next cycle, no done pulse.
REQ-032 start sampled in the same cycle as reset=0 is discarded.

Verification
REQ-033 Fill x0=10,y0=5,w=3,h=2,color=3'b010 -> 6 wren cycles in order (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), done pulses on the 7th cycle after start, busy high for 7 cycles.
REQ-034 Clipping x0=158,y0=118,w=5,h=5 -> exactly 4 writes: (158,118),(159,118),(158,119),(159,119); then done.
REQ-035 Empty command w=0 (or x0=200) -> no wren; done=1 the cycle after start; busy high for that one cycle.
REQ-036 Second start pulsed during WRITE with different color -> ignored; write count and color match the first command only.
REQ-037 reset=0 on the 3rd write cycle of a 4x4 fill -> wren=0 and busy=0 next cycle, no done; a fresh 1x1 command afterwards writes exactly one pixel.
REQ-038 Full screen x0=0,y0=0,w=160,h=120 -> 19200 writes, last at (159,119), every cycle back-to-back, then done.
